// File: rtl/ser_pkg.sv
// rtl/ser_pkg.sv - shared state encoding, idle level and counter sizing for sequence_serializer
package ser_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } ser_state_e;

    localparam logic SER_IDLE_LEVEL = 1'b0;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/sequence_serializer_if.sv
// rtl/sequence_serializer_if.sv - parallel word load handshake between word source and serializer
interface sequence_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] load_data;
    logic             load_valid;
    logic             load_ready;

    modport master (output load_data, output load_valid, input load_ready);
    modport slave  (input load_data, input load_valid, output load_ready);
endinterface

// File: rtl/sequence_serializer.sv
// rtl/sequence_serializer.sv - parallel-to-serial front end of the sequence detector; SER_PARITY_EN appends an even-parity bit
module sequence_serializer
    import ser_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    sequence_serializer_if.slave  load,
    output logic                  x,
    output logic                  x_valid,
    output logic                  busy,
    output logic                  word_done
);

    localparam int            CW        = clog2(WIDTH);
    localparam logic [CW-1:0] LAST      = CW'(WIDTH - 1);
    localparam logic [1:0]    ST_IDLE   = IDLE;
    localparam logic [1:0]    ST_SHIFT  = SHIFT;
    localparam logic [1:0]    ST_PARITY = PARITY;
`ifdef SER_PARITY_EN
    localparam logic          PAR_EN    = 1'b1;
`else
    localparam logic          PAR_EN    = 1'b0;
`endif

    logic [1:0]       state;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;
    logic             last_cycle;
    logic             take;
`ifdef SER_PARITY_EN
    logic             par;
`endif

    function automatic logic head(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    // load_ready is a pure function of state so a new word can chain onto the final bit
    assign last_cycle      = PAR_EN ? (state == ST_PARITY) : ((state == ST_SHIFT) && (cnt == LAST));
    assign load.load_ready = (state == ST_IDLE) || last_cycle;
    assign take            = load.load_valid && load.load_ready;
    assign busy            = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            sreg      <= '0;
            cnt       <= '0;
            x         <= SER_IDLE_LEVEL;
            x_valid   <= 1'b0;
            word_done <= 1'b0;
`ifdef SER_PARITY_EN
            par       <= 1'b0;
`endif
        end else if (take) begin
            state     <= ST_SHIFT;
            x         <= head(load.load_data);
            sreg      <= advance(load.load_data);
            cnt       <= '0;
            x_valid   <= 1'b1;
            word_done <= 1'b0;
`ifdef SER_PARITY_EN
            par       <= ^load.load_data;
`endif
        end else if ((state == ST_SHIFT) && (cnt != LAST)) begin
            x         <= head(sreg);
            sreg      <= advance(sreg);
            cnt       <= cnt + 1'b1;
            word_done <= !PAR_EN && (cnt == LAST - 1'b1);
`ifdef SER_PARITY_EN
        end else if (state == ST_SHIFT) begin
            state     <= ST_PARITY;
            x         <= par;
            word_done <= 1'b1;
`endif
        end else begin
            state     <= ST_IDLE;
            cnt       <= '0;
            x         <= SER_IDLE_LEVEL;
            x_valid   <= 1'b0;
            word_done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sequence_serializer.sv
// tb/tb_sequence_serializer.sv - scoreboard bench for sequence_serializer in MSB-first and LSB-first builds
module tb_sequence_serializer;

    localparam int W = 8;
`ifdef SER_PARITY_EN
    localparam int P   = W + 1;
    localparam bit PAR = 1'b1;
`else
    localparam int P   = W;
    localparam bit PAR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sequence_serializer_if #(.WIDTH(W)) m_if ();
    sequence_serializer_if #(.WIDTH(W)) l_if ();

    logic x, x_valid, busy, word_done;
    logic lx, lx_valid, lbusy, lword_done;

    sequence_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .reset(reset), .load(m_if),
        .x(x), .x_valid(x_valid), .busy(busy), .word_done(word_done)
    );

    sequence_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .reset(reset), .load(l_if),
        .x(lx), .x_valid(lx_valid), .busy(lbusy), .word_done(lword_done)
    );

    typedef struct {
        logic b;
        logic wd;
    } exp_t;

    exp_t exp_q[$];
    exp_t lexp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [W-1:0] w, input bit msb, input bit to_lsb);
        exp_t e;
        for (int i = 0; i < W; i++) begin
            e.b  = msb ? w[W-1-i] : w[i];
            e.wd = (i == W - 1) && !PAR;
            if (to_lsb) lexp_q.push_back(e); else exp_q.push_back(e);
        end
        if (PAR) begin
            e.b  = ^w;
            e.wd = 1'b1;
            if (to_lsb) lexp_q.push_back(e); else exp_q.push_back(e);
        end
    endtask

    always @(negedge clk) begin : mon_msb
        exp_t e;
        if (!reset && x_valid) begin
            n_checks++;
            if (exp_q.size() == 0) $display("FAIL msb_extra_bit got x=%0b required no bit", x);
            else begin
                n_pass++;
                e = exp_q.pop_front();
                n_checks++;
                if (x !== e.b) $display("FAIL msb_bit got=%0b required=%0b", x, e.b); else n_pass++;
                n_checks++;
                if (word_done !== e.wd) $display("FAIL msb_word_done got=%0b required=%0b", word_done, e.wd); else n_pass++;
            end
        end
    end

    always @(negedge clk) begin : mon_lsb
        exp_t e;
        if (!reset && lx_valid) begin
            n_checks++;
            if (lexp_q.size() == 0) $display("FAIL lsb_extra_bit got x=%0b required no bit", lx);
            else begin
                n_pass++;
                e = lexp_q.pop_front();
                n_checks++;
                if (lx !== e.b) $display("FAIL lsb_bit got=%0b required=%0b", lx, e.b); else n_pass++;
                n_checks++;
                if (lword_done !== e.wd) $display("FAIL lsb_word_done got=%0b required=%0b", lword_done, e.wd); else n_pass++;
            end
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        n_checks++; if (x !== 1'b0)         $display("FAIL reset_x got=%0b required=0", x); else n_pass++;
        n_checks++; if (x_valid !== 1'b0)   $display("FAIL reset_x_valid got=%0b required=0", x_valid); else n_pass++;
        n_checks++; if (busy !== 1'b0)      $display("FAIL reset_busy got=%0b required=0", busy); else n_pass++;
        n_checks++; if (word_done !== 1'b0) $display("FAIL reset_word_done got=%0b required=0", word_done); else n_pass++;
        n_checks++; if (m_if.load_ready !== 1'b1) $display("FAIL reset_load_ready got=%0b required=1", m_if.load_ready); else n_pass++;
        n_checks++; if (l_if.load_ready !== 1'b1) $display("FAIL reset_lsb_load_ready got=%0b required=1", l_if.load_ready); else n_pass++;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single_word();
        n_checks++; if (m_if.load_ready !== 1'b1) $display("FAIL single_ready_idle got=%0b required=1", m_if.load_ready); else n_pass++;
        m_if.load_data  = 8'b0111_0001;
        m_if.load_valid = 1'b1;
        push_word(8'b0111_0001, 1'b1, 1'b0);
        tick();
        m_if.load_valid = 1'b0;
        for (int c = 1; c <= P; c++) begin
            n_checks++; if (x_valid !== 1'b1) $display("FAIL single_x_valid c=%0d got=%0b required=1", c, x_valid); else n_pass++;
            n_checks++; if (busy !== 1'b1) $display("FAIL single_busy c=%0d got=%0b required=1", c, busy); else n_pass++;
            n_checks++; if (m_if.load_ready !== (c == P)) $display("FAIL single_load_ready c=%0d got=%0b required=%0b", c, m_if.load_ready, (c == P)); else n_pass++;
            n_checks++; if (word_done !== (c == P)) $display("FAIL single_word_done c=%0d got=%0b required=%0b", c, word_done, (c == P)); else n_pass++;
            tick();
        end
        n_checks++; if (x !== 1'b0)       $display("FAIL single_idle_x got=%0b required=0", x); else n_pass++;
        n_checks++; if (x_valid !== 1'b0) $display("FAIL single_idle_x_valid got=%0b required=0", x_valid); else n_pass++;
        n_checks++; if (busy !== 1'b0)    $display("FAIL single_idle_busy got=%0b required=0", busy); else n_pass++;
        n_checks++; if (exp_q.size() != 0) $display("FAIL single_drain got=%0d left required=0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_back_to_back();
        m_if.load_data  = 8'hA5;
        m_if.load_valid = 1'b1;
        push_word(8'hA5, 1'b1, 1'b0);
        tick();
        m_if.load_data = 8'h3C;
        push_word(8'h3C, 1'b1, 1'b0);
        for (int c = 1; c <= 2 * P; c++) begin
            n_checks++; if (x_valid !== 1'b1) $display("FAIL b2b_x_valid c=%0d got=%0b required=1", c, x_valid); else n_pass++;
            n_checks++; if (word_done !== (c == P || c == 2 * P)) $display("FAIL b2b_word_done c=%0d got=%0b required=%0b", c, word_done, (c == P || c == 2 * P)); else n_pass++;
            tick();
            if (c == P) m_if.load_valid = 1'b0;
        end
        n_checks++; if (x_valid !== 1'b0) $display("FAIL b2b_idle_x_valid got=%0b required=0", x_valid); else n_pass++;
        n_checks++; if (exp_q.size() != 0) $display("FAIL b2b_drain got=%0d left required=0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_busy_reject();
        m_if.load_data  = 8'h96;
        m_if.load_valid = 1'b1;
        push_word(8'h96, 1'b1, 1'b0);
        tick();
        for (int c = 1; c <= P; c++) begin
            m_if.load_valid = (c >= 2 && c <= 6);
            m_if.load_data  = 8'hFF;
            if (c >= 2 && c <= 6) begin
                n_checks++; if (m_if.load_ready !== 1'b0) $display("FAIL reject_load_ready c=%0d got=%0b required=0", c, m_if.load_ready); else n_pass++;
            end
            tick();
        end
        m_if.load_valid = 1'b0;
        n_checks++; if (x_valid !== 1'b0) $display("FAIL reject_idle_x_valid got=%0b required=0", x_valid); else n_pass++;
        n_checks++; if (exp_q.size() != 0) $display("FAIL reject_drain got=%0d left required=0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_reset_mid_word();
        m_if.load_data  = 8'hF0;
        m_if.load_valid = 1'b1;
        push_word(8'hF0, 1'b1, 1'b0);
        tick();
        m_if.load_valid = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        exp_q.delete();
        tick();
        n_checks++; if (x !== 1'b0)         $display("FAIL rstmid_x got=%0b required=0", x); else n_pass++;
        n_checks++; if (x_valid !== 1'b0)   $display("FAIL rstmid_x_valid got=%0b required=0", x_valid); else n_pass++;
        n_checks++; if (busy !== 1'b0)      $display("FAIL rstmid_busy got=%0b required=0", busy); else n_pass++;
        n_checks++; if (word_done !== 1'b0) $display("FAIL rstmid_word_done got=%0b required=0", word_done); else n_pass++;
        m_if.load_data  = 8'hAA;
        m_if.load_valid = 1'b1;
        tick();
        n_checks++; if (busy !== 1'b0) $display("FAIL rstmid_drop_busy got=%0b required=0", busy); else n_pass++;
        reset = 1'b0;
        m_if.load_data = 8'h5A;
        push_word(8'h5A, 1'b1, 1'b0);
        tick();
        m_if.load_valid = 1'b0;
        for (int c = 1; c <= P; c++) begin
            n_checks++; if (x_valid !== 1'b1) $display("FAIL rstmid_new_x_valid c=%0d got=%0b required=1", c, x_valid); else n_pass++;
            tick();
        end
        n_checks++; if (exp_q.size() != 0) $display("FAIL rstmid_drain got=%0d left required=0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_lsb_first();
        l_if.load_data  = 8'h01;
        l_if.load_valid = 1'b1;
        push_word(8'h01, 1'b0, 1'b1);
        tick();
        l_if.load_valid = 1'b0;
        for (int c = 1; c <= P; c++) begin
            n_checks++; if (lx !== (c == 1 ? 1'b1 : (c == P && PAR) ? 1'b1 : 1'b0)) $display("FAIL lsb_x c=%0d got=%0b", c, lx); else n_pass++;
            n_checks++; if (lword_done !== (c == P)) $display("FAIL lsb_done c=%0d got=%0b required=%0b", c, lword_done, (c == P)); else n_pass++;
            tick();
        end
        n_checks++; if (lx_valid !== 1'b0) $display("FAIL lsb_idle_x_valid got=%0b required=0", lx_valid); else n_pass++;
        n_checks++; if (lexp_q.size() != 0) $display("FAIL lsb_drain got=%0d left required=0", lexp_q.size()); else n_pass++;
    endtask

`ifdef SER_PARITY_EN
    task automatic test_parity(input logic [W-1:0] w, input logic par_bit);
        m_if.load_data  = w;
        m_if.load_valid = 1'b1;
        push_word(w, 1'b1, 1'b0);
        tick();
        m_if.load_valid = 1'b0;
        for (int c = 1; c <= P; c++) begin
            n_checks++; if (word_done !== (c == P)) $display("FAIL parity_done c=%0d got=%0b required=%0b", c, word_done, (c == P)); else n_pass++;
            if (c == P) begin
                n_checks++; if (x !== par_bit) $display("FAIL parity_bit w=%0h got=%0b required=%0b", w, x, par_bit); else n_pass++;
            end
            tick();
        end
        n_checks++; if (x_valid !== 1'b0) $display("FAIL parity_idle got=%0b required=0", x_valid); else n_pass++;
    endtask
`endif

    initial begin
        m_if.load_data  = '0;
        m_if.load_valid = 1'b0;
        l_if.load_data  = '0;
        l_if.load_valid = 1'b0;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_busy_reject();
        test_reset_mid_word();
        test_lsb_first();
`ifdef SER_PARITY_EN
        test_parity(8'h07, 1'b1);
        test_parity(8'h03, 1'b0);
`endif
        tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
